bird_path_ctrl: RTL and testbench

Parametrised per-bird flight controller for the duck-hunt game core. It owns one bird's position, direction, flight timeout and shot/escape outcome, and advances once per frame tick from the draw pipeline. It supersedes the fixed four-state move/clear/draw sequencer with registered coordinates, wall bounce, randomised turns, a frozen-then-falling shot sequence, and a frame-counted escape. One instance is placed per bird; all outputs feed the bird renderer and the score/round logic.

---
 rtl/bird_path_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_bird_path_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bird_path_ctrl.sv
// bird_path_ctrl
//   Flight controller for a single bird in the duck-hunt core. It owns the
//   bird's position and heading, the flight timeout, and the shot/escape
//   outcome. It advances once per frame_tick. One instance is placed per bird.
//
// Ports
//   clk          system clock
//   reset_n      asynchronous active-low reset
//   enable       game running; low freezes everything except the LFSR
//   frame_tick   one-cycle pulse per video frame
//   spawn        start a new flight (IDLE only)
//   shot         one-cycle hit pulse (FLY only)
//   out_of_ammo  level; forces escape from FLY
//   x, y         registered bird position
//   dir          {dy_up, dx_right}
//   state        IDLE=0 FLY=1 SHOT=2 FALL=3 ESCAPE=4 DONE=5
//   flying       high in FLY, SHOT, FALL, ESCAPE
//   hit          sticky: the last flight ended by being shot
//   escaped      sticky: the last flight ended by escape
//   done         one-cycle pulse on the first cycle state reads DONE
module bird_path_ctrl #(
  parameter int         X_W           = 8,
  parameter int         Y_W           = 7,
  parameter int         X_MAX         = 152,
  parameter int         Y_MAX         = 96,
  parameter int         STEP          = 1,
  parameter int         ESCAPE_FRAMES = 300,
  parameter int         FREEZE_FRAMES = 15,
  parameter logic [7:0] SEED          = 8'hA5
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable,
  input  logic           frame_tick,
  input  logic           spawn,
  input  logic           shot,
  input  logic           out_of_ammo,
  output logic [X_W-1:0] x,
  output logic [Y_W-1:0] y,
  output logic [1:0]     dir,
  output logic [2:0]     state,
  output logic           flying,
  output logic           hit,
  output logic           escaped,
  output logic           done
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FLY    = 3'd1,
    S_SHOT   = 3'd2,
    S_FALL   = 3'd3,
    S_ESCAPE = 3'd4,
    S_DONE   = 3'd5
  } state_t;

  localparam int CNT_MAX = (ESCAPE_FRAMES > FREEZE_FRAMES) ? ESCAPE_FRAMES : FREEZE_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  // Spawn comparison is done at the wider of the LFSR and the x coordinate.
  localparam int LW      = (X_W > 8) ? X_W : 8;

  localparam logic [X_W:0]     X_MAX_E = (X_W+1)'(X_MAX);
  localparam logic [X_W-1:0]   X_MAX_X = X_W'(X_MAX);
  localparam logic [X_W:0]     STEP_XE = (X_W+1)'(STEP);
  localparam logic [X_W-1:0]   STEP_X  = X_W'(STEP);
  localparam logic [Y_W:0]     Y_MAX_E = (Y_W+1)'(Y_MAX);
  localparam logic [Y_W-1:0]   Y_MAX_Y = Y_W'(Y_MAX);
  localparam logic [Y_W:0]     STEP_YE = (Y_W+1)'(STEP);
  localparam logic [Y_W-1:0]   STEP_Y  = Y_W'(STEP);
  localparam logic [CNT_W-1:0] ESC_C   = CNT_W'(ESCAPE_FRAMES);
  localparam logic [CNT_W-1:0] FRZ_C   = CNT_W'(FREEZE_FRAMES);
  localparam logic [LW-1:0]    X_MAX_L = LW'(X_MAX);

  state_t           state_reg, state_next;
  logic [X_W-1:0]   x_reg, x_next;
  logic [Y_W-1:0]   y_reg, y_next;
  logic [1:0]       dir_reg, dir_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             hit_reg, hit_next;
  logic             escaped_reg, escaped_next;
  logic             flying_reg, flying_next;
  logic             done_reg, done_next;
  logic [7:0]       lfsr_reg;

  // Datapath helpers shared by the next-state and output logic.
  logic [X_W:0]     x_sum;
  logic [X_W-1:0]   x_mv;
  logic             x_bounce;
  logic [Y_W:0]     y_sum;
  logic [Y_W-1:0]   y_fall, y_rise, y_mv;
  logic             y_dn_ovf, y_up_unf, y_bounce;
  logic             dx_mv, dy_mv;
  logic [CNT_W-1:0] cnt_inc;
  logic [LW-1:0]    lfsr_w;
  logic [X_W-1:0]   spawn_x;

  // Free-running 8-bit Fibonacci LFSR, taps 8,6,5,4. Runs even while paused so
  // that spawn positions and turns differ between pauses.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_reg <= SEED;
    end else begin
      lfsr_reg <= {lfsr_reg[6:0], lfsr_reg[7] ^ lfsr_reg[5] ^ lfsr_reg[4] ^ lfsr_reg[3]};
    end
  end

  always_comb begin : move_calc
    x_mv     = x_reg;
    x_bounce = 1'b0;
    // One extra bit on the sum so that stepping past X_MAX is visible.
    x_sum    = {1'b0, x_reg} + STEP_XE;
    if (dir_reg[0]) begin
      if (x_sum > X_MAX_E) begin
        x_mv     = X_MAX_X;
        x_bounce = 1'b1;
      end else begin
        x_mv = x_sum[X_W-1:0];
      end
    end else begin
      if (x_reg < STEP_X) begin
        x_mv     = '0;
        x_bounce = 1'b1;
      end else begin
        x_mv = x_reg - STEP_X;
      end
    end

    // y grows toward the ground; dy_up=1 means y decreasing.
    y_sum    = {1'b0, y_reg} + STEP_YE;
    y_dn_ovf = (y_sum > Y_MAX_E);
    y_fall   = y_dn_ovf ? Y_MAX_Y : y_sum[Y_W-1:0];
    y_up_unf = (y_reg < STEP_Y);
    y_rise   = y_up_unf ? '0 : (y_reg - STEP_Y);
    y_mv     = dir_reg[1] ? y_rise : y_fall;
    y_bounce = dir_reg[1] ? y_up_unf : y_dn_ovf;

    // A bounce already inverts the axis; a random turn is only considered on
    // an axis that did not bounce this frame.
    dx_mv = dir_reg[0] ^ (x_bounce | (lfsr_reg[1:0] == 2'b00));
    dy_mv = dir_reg[1] ^ (y_bounce | (lfsr_reg[3:2] == 2'b00));

    cnt_inc = cnt_reg + 1'b1;

    lfsr_w  = LW'(lfsr_reg);
    spawn_x = (lfsr_w > X_MAX_L) ? X_MAX_X : X_W'(lfsr_w);
  end

  // State register plus all registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg   <= S_IDLE;
      x_reg       <= '0;
      y_reg       <= Y_MAX_Y;
      dir_reg     <= 2'b11;
      cnt_reg     <= '0;
      hit_reg     <= 1'b0;
      escaped_reg <= 1'b0;
      flying_reg  <= 1'b0;
      done_reg    <= 1'b0;
    end else begin
      state_reg   <= state_next;
      x_reg       <= x_next;
      y_reg       <= y_next;
      dir_reg     <= dir_next;
      cnt_reg     <= cnt_next;
      hit_reg     <= hit_next;
      escaped_reg <= escaped_next;
      flying_reg  <= flying_next;
      done_reg    <= done_next;
    end
  end

  // Next-state logic. In FLY a shot wins over both escape causes and does not
  // need a frame_tick.
  always_comb begin : next_state
    state_next = state_reg;
    if (enable) begin
      unique case (state_reg)
        S_IDLE:   if (spawn) state_next = S_FLY;
        S_FLY: begin
          if (shot)                                  state_next = S_SHOT;
          else if (out_of_ammo)                      state_next = S_ESCAPE;
          else if (frame_tick && (cnt_inc == ESC_C)) state_next = S_ESCAPE;
        end
        S_SHOT:   if (frame_tick && (cnt_inc == FRZ_C))   state_next = S_FALL;
        S_FALL:   if (frame_tick && (y_fall == Y_MAX_Y))  state_next = S_DONE;
        S_ESCAPE: if (frame_tick && (y_rise == '0))       state_next = S_DONE;
        S_DONE:   if (frame_tick)                         state_next = S_IDLE;
        default:  state_next = S_IDLE;
      endcase
    end
  end

  // Output / datapath next values.
  always_comb begin : output_logic
    x_next       = x_reg;
    y_next       = y_reg;
    dir_next     = dir_reg;
    cnt_next     = cnt_reg;
    hit_next     = hit_reg;
    escaped_next = escaped_reg;
    if (enable) begin
      unique case (state_reg)
        S_IDLE: begin
          if (spawn) begin
            x_next       = spawn_x;
            y_next       = Y_MAX_Y;
            dir_next     = {1'b1, lfsr_reg[0]};
            cnt_next     = '0;
            hit_next     = 1'b0;
            escaped_next = 1'b0;
          end
        end
        S_FLY: begin
          if (shot) begin
            cnt_next = '0;
          end else if (out_of_ammo) begin
            dir_next[1] = 1'b1;
          end else if (frame_tick) begin
            x_next   = x_mv;
            y_next   = y_mv;
            cnt_next = cnt_inc;
            // Escaping birds always head up.
            dir_next = {dy_mv | (cnt_inc == ESC_C), dx_mv};
          end
        end
        S_SHOT: if (frame_tick) cnt_next = cnt_inc;
        S_FALL: begin
          if (frame_tick) begin
            y_next = y_fall;
            if (y_fall == Y_MAX_Y) hit_next = 1'b1;
          end
        end
        S_ESCAPE: begin
          if (frame_tick) begin
            y_next = y_rise;
            if (y_rise == '0) escaped_next = 1'b1;
          end
        end
        default: ;
      endcase
    end
    flying_next = (state_next == S_FLY) || (state_next == S_SHOT) ||
                  (state_next == S_FALL) || (state_next == S_ESCAPE);
    // While paused state_next equals state_reg, so done cannot stretch.
    done_next   = (state_next == S_DONE) && (state_reg != S_DONE);
  end

  assign x       = x_reg;
  assign y       = y_reg;
  assign dir     = dir_reg;
  assign state   = state_reg;
  assign flying  = flying_reg;
  assign hit     = hit_reg;
  assign escaped = escaped_reg;
  assign done    = done_reg;

endmodule

// File: tb/tb_bird_path_ctrl.sv
module tb_bird_path_ctrl;

  localparam int ESC  = 20;
  localparam int FRZ  = 15;
  localparam int XMAX = 152;
  localparam int YMAX = 96;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       enable;
  logic       frame_tick;
  logic       spawn;
  logic       shot;
  logic       out_of_ammo;
  logic [7:0] x;
  logic [6:0] y;
  logic [1:0] dir;
  logic [2:0] state;
  logic       flying;
  logic       hit;
  logic       escaped;
  logic       done;

  always #5 clk = ~clk;

  bird_path_ctrl #(
    .X_W(8), .Y_W(7), .X_MAX(XMAX), .Y_MAX(YMAX), .STEP(1),
    .ESCAPE_FRAMES(ESC), .FREEZE_FRAMES(FRZ), .SEED(8'hA5)
  ) dut (
    .clk(clk), .reset_n(reset_n), .enable(enable), .frame_tick(frame_tick),
    .spawn(spawn), .shot(shot), .out_of_ammo(out_of_ammo),
    .x(x), .y(y), .dir(dir), .state(state), .flying(flying),
    .hit(hit), .escaped(escaped), .done(done)
  );

  // Reference LFSR: 8-bit Fibonacci, taps 8,6,5,4, free running.
  logic [7:0] m_lfsr;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) m_lfsr <= 8'hA5;
    else          m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  // Reference flight model.
  int         m_x, m_y, m_cnt, m_state;
  logic [1:0] m_dir;
  logic       m_hit, m_esc;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input bit exp_done);
    chk({tag, " state"},   32'(state),   32'(m_state));
    chk({tag, " x"},       32'(x),       32'(m_x));
    chk({tag, " y"},       32'(y),       32'(m_y));
    chk({tag, " dir"},     32'(dir),     32'(m_dir));
    chk({tag, " hit"},     32'(hit),     32'(m_hit));
    chk({tag, " escaped"}, 32'(escaped), 32'(m_esc));
    chk({tag, " done"},    32'(done),    32'(exp_done));
    chk({tag, " flying"},  32'(flying),  32'((m_state >= 1) && (m_state <= 4)));
  endtask

  task automatic model_reset();
    m_state = 0; m_x = 0; m_y = YMAX; m_dir = 2'b11;
    m_hit = 1'b0; m_esc = 1'b0; m_cnt = 0;
  endtask

  // Advance the model by one enabled frame using the LFSR value the DUT sees.
  task automatic model_tick(output bit d);
    int nx, ny;
    bit bx, by;
    logic ndx, ndy;
    d = 1'b0;
    case (m_state)
      1: begin
        nx = m_x + (m_dir[0] ? 1 : -1);
        bx = 1'b0;
        if (nx < 0)         begin nx = 0;    bx = 1'b1; end
        else if (nx > XMAX) begin nx = XMAX; bx = 1'b1; end
        ny = m_y + (m_dir[1] ? -1 : 1);
        by = 1'b0;
        if (ny < 0)         begin ny = 0;    by = 1'b1; end
        else if (ny > YMAX) begin ny = YMAX; by = 1'b1; end
        ndx = m_dir[0];
        if (bx) ndx = ~ndx;
        else if (m_lfsr[1:0] == 2'b00) ndx = ~ndx;
        ndy = m_dir[1];
        if (by) ndy = ~ndy;
        else if (m_lfsr[3:2] == 2'b00) ndy = ~ndy;
        m_x = nx; m_y = ny; m_dir = {ndy, ndx};
        m_cnt++;
        if (m_cnt == ESC) begin
          m_state  = 4;
          m_dir[1] = 1'b1;
        end
      end
      2: begin
        m_cnt++;
        if (m_cnt == FRZ) m_state = 3;
      end
      3: begin
        m_y = (m_y + 1 > YMAX) ? YMAX : m_y + 1;
        if (m_y == YMAX) begin m_state = 5; m_hit = 1'b1; d = 1'b1; end
      end
      4: begin
        m_y = (m_y - 1 < 0) ? 0 : m_y - 1;
        if (m_y == 0) begin m_state = 5; m_esc = 1'b1; d = 1'b1; end
      end
      5: m_state = 0;
      default: ;
    endcase
  endtask

  // Called at a negedge: one frame_tick cycle, then one quiet cycle.
  task automatic do_tick(input string tag);
    bit d;
    d = 1'b0;
    frame_tick = 1'b1;
    if (enable) model_tick(d);
    @(negedge clk);
    frame_tick = 1'b0;
    check_all(tag, d);
    $display("tick %-10s state=%0d x=%0d y=%0d dir=%0d done=%0d", tag, state, x, y, dir, done);
    @(negedge clk);
    chk({tag, " done_gap"}, 32'(done), 32'd0);
  endtask

  task automatic do_spawn(input bit release_reset);
    spawn = 1'b1;
    if (release_reset) reset_n = 1'b1;
    m_x   = (int'(m_lfsr) > XMAX) ? XMAX : int'(m_lfsr);
    m_y   = YMAX;
    m_dir = {1'b1, m_lfsr[0]};
    m_hit = 1'b0; m_esc = 1'b0; m_cnt = 0; m_state = 1;
    @(negedge clk);
    spawn = 1'b0;
    check_all("spawn", 1'b0);
    $display("spawn state=%0d x=%0d y=%0d dir=%0d", state, x, y, dir);
  endtask

  task automatic do_shot(input bit with_tick, input bit with_oom);
    shot        = 1'b1;
    frame_tick  = with_tick;
    out_of_ammo = with_oom;
    m_state = 2; m_cnt = 0;
    @(negedge clk);
    shot = 1'b0; frame_tick = 1'b0; out_of_ammo = 1'b0;
    check_all("shot", 1'b0);
    chk("shot_state_hand", 32'(state), 32'd2);
    $display("shot tick=%0d oom=%0d state=%0d x=%0d y=%0d", with_tick, with_oom, state, x, y);
  endtask

  task automatic run_to_done(input string tag, input int st);
    for (int i = 0; i < YMAX + 2 && m_state == st; i++) do_tick(tag);
    chk({tag, " reached_done"}, 32'(state), 32'd5);
  endtask

  initial begin
    reset_n = 1'b0; enable = 1'b1; frame_tick = 1'b0;
    spawn = 1'b1; shot = 1'b0; out_of_ammo = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all("reset", 1'b0);

    // Spawn on the first edge after reset: LFSR=0xA5 > 152 so x clamps to 152.
    do_spawn(1'b1);
    chk("spawn_x_hand",   32'(x),   32'd152);
    chk("spawn_y_hand",   32'(y),   32'd96);
    chk("spawn_dir_hand", 32'(dir), 32'd3);

    // At the right wall moving right: the first frame clamps and bounces.
    do_tick("fly1");
    chk("wall_x_hand",  32'(x),      32'd152);
    chk("wall_dx_hand", 32'(dir[0]), 32'd0);
    for (int i = 2; i <= 10; i++) do_tick("fly");

    // Paused for 50 frames: nothing but the LFSR may move.
    enable = 1'b0;
    for (int i = 0; i < 50; i++) do_tick("paused");
    enable = 1'b1;

    // Counter resumed at 10: the 20th enabled frame forces ESCAPE.
    for (int i = 11; i <= 19; i++) do_tick("fly");
    chk("pre_timeout_state", 32'(state), 32'd1);
    do_tick("fly20");
    chk("timeout_state_hand", 32'(state),  32'd4);
    chk("timeout_dy_hand",    32'(dir[1]), 32'd1);
    run_to_done("escape", 4);
    chk("esc_y_hand",       32'(y),       32'd0);
    chk("esc_escaped_hand", 32'(escaped), 32'd1);
    chk("esc_hit_hand",     32'(hit),     32'd0);
    do_tick("done2idle");
    chk("idle_state_hand", 32'(state), 32'd0);

    // Shot mid-frame, freeze, fall to ground.
    do_spawn(1'b0);
    for (int i = 0; i < 3; i++) do_tick("fly");
    do_shot(1'b0, 1'b0);
    for (int i = 0; i < FRZ - 1; i++) do_tick("frozen");
    chk("still_shot_hand", 32'(state), 32'd2);
    do_tick("frozen15");
    chk("fall_state_hand", 32'(state), 32'd3);
    run_to_done("fall", 3);
    chk("fall_y_hand",       32'(y),       32'd96);
    chk("fall_hit_hand",     32'(hit),     32'd1);
    chk("fall_escaped_hand", 32'(escaped), 32'd0);
    do_tick("done2idle");

    // Shot, out_of_ammo and frame_tick together: SHOT wins, no move.
    do_spawn(1'b0);
    for (int i = 0; i < 2; i++) do_tick("fly");
    do_shot(1'b1, 1'b1);
    for (int i = 0; i < FRZ; i++) do_tick("frozen");
    run_to_done("fall", 3);
    chk("combo_hit_hand", 32'(hit), 32'd1);
    do_tick("done2idle");

    // Reset during FALL: immediate return to reset values, no done pulse.
    do_spawn(1'b0);
    for (int i = 0; i < 3; i++) do_tick("fly");
    do_shot(1'b0, 1'b0);
    for (int i = 0; i < FRZ; i++) do_tick("frozen");
    chk("in_fall_hand", 32'(state), 32'd3);
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("async_rst_state", 32'(state), 32'd0);
    chk("async_rst_y",     32'(y),     32'd96);
    chk("async_rst_hit",   32'(hit),   32'd0);
    chk("async_rst_done",  32'(done),  32'd0);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check_all("in_reset", 1'b0);
    end
    reset_n = 1'b1;
    @(negedge clk);
    check_all("post_reset", 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    n_errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
